// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: ALU, destination select, BEQ decision.
// Define EX_MULT_EN to include the iterative shift-add multiplier (ALUCtrl 11) and its stall FSM.
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int MUL_CNT_W = 5
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              Valid_In,
  input  logic              Flush_In,
  input  logic              RegWriteEN_In,
  input  logic              Mem2RegSEL_In,
  input  logic              MemWriteEN_In,
  input  logic              Branch_In,
  input  logic [3:0]        ALUCtrl_In,
  input  logic              ALUSrc_In,
  input  logic              RegDstSEL_In,
  input  logic [DATA_W-1:0] RegData1_In,
  input  logic [DATA_W-1:0] RegData2_In,
  input  logic [4:0]        RTAddr_In,
  input  logic [4:0]        RDAddr_In,
  input  logic [4:0]        Shamt_In,
  input  logic [DATA_W-1:0] ImmSignExt_In,
  input  logic [DATA_W-1:0] ImmZeroExt_In,
  output logic              Stall_Out,
  output logic              Valid_Out,
  output logic              RegWriteEN_Out,
  output logic              Mem2RegSEL_Out,
  output logic              MemWriteEN_Out,
  output logic              BranchTaken_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [DATA_W-1:0] StoreData_Out,
  output logic [4:0]        DstAddr_Out
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,  OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA = 4'd9,  OP_LUI = 4'd10, OP_MULT = 4'd11;

  // The multiplier runs one iteration per operand bit, counted by a MUL_CNT_W-bit counter.
  if ((1 << MUL_CNT_W) != DATA_W) begin : g_bad_cfg
    $error("ex_mem_stage: 2**MUL_CNT_W must equal DATA_W");
  end

  logic              is_logic_op;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] ex_result;
  logic              ex_fire;

  // Logical immediates (ANDI/ORI/XORI) take the zero-extended form.
  assign is_logic_op = (ALUCtrl_In == OP_AND) || (ALUCtrl_In == OP_OR) || (ALUCtrl_In == OP_XOR);
  assign op_b = ALUSrc_In ? (is_logic_op ? ImmZeroExt_In : ImmSignExt_In) : RegData2_In;

  always_comb begin
    // NOTE: default assignment first so every path drives the result and no latch is inferred.
    alu_result = '0;
    case (ALUCtrl_In)
      OP_ADD: alu_result = RegData1_In + op_b;
      OP_SUB: alu_result = RegData1_In - op_b;
      OP_AND: alu_result = RegData1_In & op_b;
      OP_OR:  alu_result = RegData1_In | op_b;
      OP_XOR: alu_result = RegData1_In ^ op_b;
      OP_NOR: alu_result = ~(RegData1_In | op_b);
      OP_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(RegData1_In) < $signed(op_b))};
      OP_SLL: alu_result = RegData2_In << Shamt_In;
      OP_SRL: alu_result = RegData2_In >> Shamt_In;
      OP_SRA: alu_result = $signed(RegData2_In) >>> Shamt_In;
      OP_LUI: alu_result = {op_b[15:0], {(DATA_W-16){1'b0}}};
      default: alu_result = '0;
    endcase
  end

`ifdef EX_MULT_EN
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

  logic [1:0]           state;
  logic [DATA_W-1:0]    mul_a, mul_b, mul_acc;
  logic [MUL_CNT_W-1:0] mul_cnt;
  logic                 is_mult, mul_start;

  assign is_mult   = (ALUCtrl_In == OP_MULT);
  assign mul_start = RESET_N && (state == S_IDLE) && Valid_In && is_mult && !Flush_In;
  assign Stall_Out = RESET_N && !Flush_In && (mul_start || (state == S_BUSY));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (Flush_In) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (mul_start) begin
          mul_a   <= RegData1_In;
          mul_b   <= op_b;
          mul_acc <= '0;
          mul_cnt <= '0;
          state   <= S_BUSY;
        end
        S_BUSY: begin
          if (mul_b[0]) mul_acc <= mul_acc + mul_a;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == MUL_CNT_W'(DATA_W - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // In DONE the ID/EX register still holds the MULT's controls, so they retire with the product.
  assign ex_fire   = Valid_In && !Flush_In &&
                     (((state == S_IDLE) && !is_mult) || (state == S_DONE));
  assign ex_result = (state == S_DONE) ? mul_acc : alu_result;
`else
  assign Stall_Out = 1'b0;
  assign ex_fire   = Valid_In && !Flush_In;
  assign ex_result = alu_result;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      Valid_Out       <= 1'b0;
      RegWriteEN_Out  <= 1'b0;
      Mem2RegSEL_Out  <= 1'b0;
      MemWriteEN_Out  <= 1'b0;
      BranchTaken_Out <= 1'b0;
      ALUResult_Out   <= '0;
      StoreData_Out   <= '0;
      DstAddr_Out     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      Valid_Out       <= ex_fire;
      RegWriteEN_Out  <= ex_fire && RegWriteEN_In;
      MemWriteEN_Out  <= ex_fire && MemWriteEN_In;
      BranchTaken_Out <= ex_fire && Branch_In && (RegData1_In == RegData2_In);
      // Bubbles leave the data fields untouched to save toggling.
      if (ex_fire) begin
        Mem2RegSEL_Out <= Mem2RegSEL_In;
        ALUResult_Out  <= ex_result;
        StoreData_Out  <= RegData2_In;
        DstAddr_Out    <= RegDstSEL_In ? RDAddr_In : RTAddr_In;
      end
    end
  end

endmodule
